// File: rtl/fram_pkg.sv
// Shared definitions for the FM28V102A controller: FSM encoding, timing defaults,
// requester count and byte-enable field layout.
package fram_pkg;

  localparam int unsigned ACC_CYC_DEF = 6;
  localparam int unsigned PRE_CYC_DEF = 9;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned BE_UB  = 1;
  localparam int unsigned BE_LB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_PRECHARGE = 3'd4
  } fram_state_e;

  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    return {{8{be[BE_UB]}}, {8{be[BE_LB]}}};
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/fram_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, priority flips away from the
// requester served on each accepted grant.
module fram_rr_arb
  import fram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_accept,
  output logic [N_REQ-1:0] o_grant
);

  // r_prio names the requester that wins a tie; it is the one not served last.
  logic r_prio;

  always_comb begin
    o_grant = '0;
    if (&i_valid) begin
      o_grant[r_prio] = 1'b1;
    end else begin
      o_grant = i_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_accept && (o_grant != '0)) begin
      r_prio <= ~o_grant[1];
    end
  end

endmodule

// File: rtl/fram_ctrl.sv
// FM28V102A parallel FRAM controller with two round-robin requesters.
// Sequence per access: IDLE -> SETUP -> ACCESS(ACC_CYC) -> HOLD -> PRECHARGE(PRE_CYC).
module fram_ctrl
  import fram_pkg::*;
#(
  parameter int unsigned ACC_CYC = ACC_CYC_DEF,
  parameter int unsigned PRE_CYC = PRE_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ*BE_W-1:0]   req_be,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       fram_addr,
  inout  wire  [DATA_W-1:0]       fram_dq,
  output logic                    fram_ce_n,
  output logic                    fram_we_n,
  output logic                    fram_oe_n,
  output logic                    fram_ub_n,
  output logic                    fram_lb_n
);

  localparam int unsigned CNT_W = cnt_width(ACC_CYC, PRE_CYC);

  fram_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_owner;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;

  logic [N_REQ-1:0]  w_grant;
  logic              w_gnt_id;
  logic              w_accept;
  logic              w_cnt_zero;
  logic              w_dq_oe;

  assign w_accept   = (r_state == ST_IDLE) && (req_valid != '0);
  assign w_gnt_id   = w_grant[1];
  assign w_cnt_zero = (r_cnt == '0);

  fram_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Gated by rst_n so no grant is offered while reset is held with requests pending.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid != '0) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
        w_cnt_nxt   = CNT_W'(ACC_CYC - 1);
      end
      ST_ACCESS: begin
        if (w_cnt_zero) w_state_nxt = ST_HOLD;
        else            w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_HOLD: begin
        w_state_nxt = ST_PRECHARGE;
        w_cnt_nxt   = CNT_W'(PRE_CYC - 1);
      end
      ST_PRECHARGE: begin
        if (w_cnt_zero) w_state_nxt = ST_IDLE;
        else            w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset releases them at once.
  always_comb begin
    fram_ce_n = 1'b1;
    fram_we_n = 1'b1;
    fram_oe_n = 1'b1;
    fram_ub_n = 1'b1;
    fram_lb_n = 1'b1;
    if (r_state == ST_ACCESS) begin
      fram_ce_n = 1'b0;
      fram_we_n = ~r_we;
      fram_oe_n = r_we;
      fram_ub_n = ~r_be[BE_UB];
      fram_lb_n = ~r_be[BE_LB];
    end
  end

  assign w_dq_oe = r_we && ((r_state == ST_SETUP) || (r_state == ST_ACCESS) ||
                            (r_state == ST_HOLD));
  assign fram_dq = w_dq_oe ? r_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we[w_gnt_id];
      r_addr  <= req_addr[{w_gnt_id, 4'b0000} +: ADDR_W];
      r_wdata <= req_wdata[{w_gnt_id, 4'b0000} +: DATA_W];
      r_be    <= req_be[{w_gnt_id, 1'b0} +: BE_W];
      r_owner <= w_gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= '0;
      if ((r_state == ST_ACCESS) && w_cnt_zero && !r_we) begin
        r_rsp_valid[r_owner] <= 1'b1;
        r_rdata              <= fram_dq & be_mask(r_be);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign fram_addr = r_addr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fram_ctrl.sv
// Directed and randomized bench for fram_ctrl with a behavioural FM28V102A model
// and an independent word-level reference memory.
module tb_fram_ctrl;

  localparam int ACC    = 6;
  localparam int PRE    = 9;
  localparam int PERIOD = ACC + PRE + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] fram_addr;
  wire  [15:0] fram_dq;
  logic        fram_ce_n, fram_we_n, fram_oe_n, fram_ub_n, fram_lb_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fram_ctrl #(.ACC_CYC(ACC), .PRE_CYC(PRE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .fram_addr(fram_addr), .fram_dq(fram_dq),
    .fram_ce_n(fram_ce_n), .fram_we_n(fram_we_n), .fram_oe_n(fram_oe_n),
    .fram_ub_n(fram_ub_n), .fram_lb_n(fram_lb_n)
  );

  // FM28V102A functional model: byte writes while ce/we low, reads drive junk on unselected bytes.
  logic [15:0] dev_mem [0:65535];
  logic [15:0] dev_rd;
  logic        dev_drv;
  always_comb begin
    dev_drv = !fram_ce_n && !fram_oe_n && fram_we_n;
    dev_rd  = {fram_ub_n ? 8'hEE : dev_mem[fram_addr][15:8],
               fram_lb_n ? 8'hEE : dev_mem[fram_addr][7:0]};
  end
  assign fram_dq = dev_drv ? dev_rd : 16'hzzzz;

  always @(posedge clk) begin
    if (rst_n && !fram_ce_n && !fram_we_n) begin
      if (!fram_ub_n) dev_mem[fram_addr][15:8] = fram_dq[15:8];
      if (!fram_lb_n) dev_mem[fram_addr][7:0]  = fram_dq[7:0];
    end
  end

  logic [15:0] ref_mem [int unsigned];

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic [1:0] be);
    logic [15:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    return {be[1] ? v[15:8] : 8'h00, be[0] ? v[7:0] : 8'h00};
  endfunction

  function automatic void ref_write(input logic [15:0] a, input logic [15:0] d,
                                    input logic [1:0] be);
    logic [15:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    if (be[1]) v[15:8] = d[15:8];
    if (be[0]) v[7:0]  = d[7:0];
    ref_mem[a] = v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: address frozen while ce_n low, we/oe exclusive, ready only when idle.
  logic        mon_ce_low = 1'b0;
  logic [15:0] mon_addr   = 16'h0;
  always @(negedge clk) begin
    if (!fram_ce_n && mon_ce_low) check("addr_stable", fram_addr, mon_addr);
    if (!fram_we_n || !fram_oe_n) check("we_oe_excl", {fram_we_n, fram_oe_n} == 2'b00, 0);
    if (req_ready != 2'b00) check("ready_only_idle", busy, 0);
    mon_ce_low = !fram_ce_n;
    mon_addr   = fram_addr;
  end

  task automatic issue(input int id, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    bit got = 0;
    @(negedge clk);
    req_we[id]           = we;
    req_addr[id*16 +: 16]  = a;
    req_wdata[id*16 +: 16] = d;
    req_be[id*2 +: 2]      = be;
    req_valid[id]        = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (req_ready != 2'b00) begin got = 1; break; end
      @(negedge clk);
    end
    check("grant", req_ready, 32'(1 << id));
    if (got) @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    if (we) ref_write(a, d, be);
  endtask

  task automatic wait_rsp(input int id, input logic [15:0] exp);
    bit got = 0;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid != 2'b00) begin got = 1; break; end
      @(negedge clk);
    end
    check("rsp_valid", rsp_valid, 32'(1 << id));
    check("rsp_rdata", rsp_rdata, exp);
    if (got) begin
      @(negedge clk);
      check("rsp_pulse", rsp_valid, 0);
    end
  endtask

  task automatic xfer(input int id, input bit we, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] be, input logic [15:0] exp);
    issue(id, we, a, d, be);
    if (!we) wait_rsp(id, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants, rsps;
    int          gnt_id [4];
    int          gnt_cyc[4];
    int          own_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] pool[6];
    bit          seen;

    for (int i = 0; i < 65536; i++) dev_mem[i] = 16'h0000;
    dev_mem[16'h0100] = 16'hBEEF; ref_mem[16'h0100] = 16'hBEEF;
    dev_mem[16'h0200] = 16'hC3A7; ref_mem[16'h0200] = 16'hC3A7;

    // Reset with both requests pending: nothing granted, bus idle.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = 4'hF;
    #12;
    check("rst_strobes", {fram_ce_n, fram_we_n, fram_oe_n, fram_ub_n, fram_lb_n}, 5'h1F);
    check("rst_addr", fram_addr, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters continuously valid: grants alternate from requester 0.
    @(negedge clk);
    req_addr  = {16'h0200, 16'h0100};
    req_be    = {2'b10, 2'b11};
    req_valid = 2'b11;
    grants = 0;
    rsps   = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (req_ready != 2'b00 && grants < 4) begin
        gnt_id[grants]  = int'(req_ready[1]);
        gnt_cyc[grants] = cyc;
        own_q.push_back(int'(req_ready[1]));
        exp_q.push_back(req_ready[1] ? ref_read(16'h0200, 2'b10) : ref_read(16'h0100, 2'b11));
        grants++;
      end
      if (rsp_valid != 2'b00) begin
        if (own_q.size() == 0) begin
          check("alt_rsp_unexpected", rsp_valid, 0);
        end else begin
          check("alt_rsp_owner", rsp_valid, 32'(1 << own_q.pop_front()));
          check("alt_rsp_rdata", rsp_rdata, exp_q.pop_front());
        end
        rsps++;
      end
      if (grants == 4 && rsps == 4) break;
      @(negedge clk);
      if (grants == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    check("alt_grants", grants, 4);
    check("alt_rsps", rsps, 4);
    for (int i = 0; i < 4; i++) check("alt_order", gnt_id[i], i % 2);
    for (int i = 0; i < 3; i++) check("alt_period", gnt_cyc[i+1] - gnt_cyc[i], PERIOD);

    // Full-word write then read back.
    xfer(0, 1, 16'h0010, 16'hA55A, 2'b11, 16'h0);
    xfer(0, 0, 16'h0010, 16'h0,    2'b11, 16'hA55A);
    // Upper-byte-only write over all-ones.
    xfer(1, 1, 16'h0020, 16'hFFFF, 2'b11, 16'h0);
    xfer(1, 1, 16'h0020, 16'h1234, 2'b10, 16'h0);
    xfer(0, 0, 16'h0020, 16'h0,    2'b11, 16'h12FF);
    // Zero byte enables: write changes nothing, read still responds with zero.
    xfer(0, 1, 16'h0010, 16'h0000, 2'b00, 16'h0);
    xfer(1, 0, 16'h0010, 16'h0,    2'b00, 16'h0000);
    xfer(0, 0, 16'h0010, 16'h0,    2'b01, 16'h005A);
    xfer(1, 0, 16'h0010, 16'h0,    2'b11, 16'hA55A);
    // Address extremes.
    xfer(0, 1, 16'hFFFF, 16'h5AC3, 2'b11, 16'h0);
    xfer(1, 1, 16'h0000, 16'h3C96, 2'b11, 16'h0);
    xfer(0, 0, 16'hFFFF, 16'h0,    2'b11, 16'h5AC3);
    xfer(1, 0, 16'h0000, 16'h0,    2'b11, 16'h3C96);

    // Reset asserted in the third ACCESS cycle of a write.
    issue(0, 1, 16'h0055, 16'hDEAD, 2'b11);
    repeat (3) @(negedge clk);
    check("abort_in_access", {fram_ce_n, fram_we_n}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {fram_ce_n, fram_we_n, fram_oe_n}, 3'b111);
    check("abort_busy", busy, 0);
    check("abort_addr", fram_addr, 0);
    ref_mem.delete(16'h0055);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    check("abort_no_rsp", seen, 0);
    xfer(1, 1, 16'h0066, 16'h7E81, 2'b11, 16'h0);
    xfer(0, 0, 16'h0066, 16'h0,    2'b11, 16'h7E81);

    // Randomized mix over a small address pool against the reference memory.
    pool = '{16'h0000, 16'hFFFF, 16'h0010, 16'h0020, 16'h8001, 16'h0100};
    for (int i = 0; i < 40; i++) begin
      int          id;
      bit          we;
      logic [15:0] a, d;
      logic [1:0]  be;
      id = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 5)];
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      xfer(id, we, a, d, be, ref_read(a, be));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
